// File: rtl/slow_clock.sv
// Bit-rate clock generator: divides CLK by DIV into SCLK and re-phases it on
// every SYNC transition so the SCLK falling edge lands in the middle of a bit.
module slow_clock #(
  parameter int DIV         = 434,
  parameter int SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic SYNC,
  output logic SCLK
);

  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_sync_d;
  logic [CW-1:0]          r_cnt;
  logic                   r_sclk;

  logic                   w_sync_q;
  logic                   w_edge;
  logic [CW-1:0]          w_cnt_nxt;

  // Metastability synchronizer plus one extra flop for edge detection.
  // The line idles high, so reset loads 1 to avoid a false edge on release.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sync   <= '1;
      r_sync_d <= 1'b1;
    end else begin
      r_sync   <= {r_sync[SYNC_STAGES-2:0], SYNC};
      r_sync_d <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_sync_q = r_sync[SYNC_STAGES-1];
  assign w_edge   = w_sync_q ^ r_sync_d;

  // Next phase: any line transition reloads, otherwise count and wrap.
  always_comb begin
    w_cnt_nxt = r_cnt + CW'(1);
    if (w_edge || (r_cnt == CW'(DIV - 1))) begin
      w_cnt_nxt = '0;
    end
  end

  // NOTE: SCLK is decoded from the *next* count and registered alongside it,
  // so it stays cycle-aligned with cnt and is glitch-free as a flop output.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt  <= '0;
      r_sclk <= 1'b1;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_sclk <= (w_cnt_nxt < CW'(HALF));
    end
  end

  assign SCLK = r_sclk;

endmodule

// File: tb/tb_slow_clock.sv
// Self-checking bench for slow_clock: DIV=8 and DIV=9 instances share inputs and
// are compared each cycle against a timestamp-based reference model.
module tb_slow_clock;

  localparam int S = 2;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic SYNC = 1'b1;
  logic sclk8;
  logic sclk9;

  int n_checks = 0;
  int n_fail   = 0;

  slow_clock #(.DIV(8), .SYNC_STAGES(S)) u_dut8 (
    .CLK(CLK), .RST(RST), .SYNC(SYNC), .SCLK(sclk8)
  );
  slow_clock #(.DIV(9), .SYNC_STAGES(S)) u_dut9 (
    .CLK(CLK), .RST(RST), .SYNC(SYNC), .SCLK(sclk9)
  );

  always #5 CLK = ~CLK;

  // Reference model: SCLK is high for the first DIV/2 cycles after the most
  // recent resync point (reset or detected line transition), repeating every DIV.
  int   cyc  = 0;
  int   last = 0;
  logic hist[$];

  task automatic model_update(input logic rst, input logic sync);
    cyc++;
    if (rst) begin
      hist.delete();
      for (int i = 0; i <= S; i++) hist.push_back(1'b1);
      last = cyc;
    end else begin
      if (hist[S-1] != hist[S]) last = cyc;
      hist.push_front(sync);
      void'(hist.pop_back());
    end
  endtask

  function automatic logic model_sclk(input int div);
    return ((cyc - last) % div) < (div / 2);
  endfunction

  task automatic check(input string name, input logic actual, input logic expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %b, expected %b", name, cyc, actual, expected);
    end
  endtask

  task automatic step(input logic rst, input logic sync);
    RST  = rst;
    SYNC = sync;
    @(posedge CLK);
    model_update(rst, sync);
    #1;
    check("model_div8", sclk8, model_sclk(8));
    check("model_div9", sclk9, model_sclk(9));
  endtask

  typedef struct {
    logic rst;
    logic sync;
    logic exp8;
    logic exp9;
  } vec_t;

  vec_t tbl[15];
  int   fall_dist;
  logic cur_sync;

  initial begin
    for (int i = 0; i <= S; i++) hist.push_back(1'b1);

    // Reset for 3 cycles, then free-run with SYNC idle high.
    tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b1};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b1};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b1};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b1};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b1};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b1};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b1};
    tbl[12] = '{1'b0, 1'b1, 1'b1, 1'b1};
    tbl[13] = '{1'b0, 1'b1, 1'b1, 1'b1};
    tbl[14] = '{1'b0, 1'b1, 1'b0, 1'b1};

    for (int i = 0; i < 15; i++) begin
      step(tbl[i].rst, tbl[i].sync);
      check("table_div8", sclk8, tbl[i].exp8);
      check("table_div9", sclk9, tbl[i].exp9);
    end

    // Ten full free-running periods with SYNC steady.
    for (int i = 0; i < 80; i++) step(1'b0, 1'b1);

    // Falling-edge resync while SCLK low: reset, run to cnt=6, then drop SYNC.
    step(1'b1, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1);
    check("cnt6_low", sclk8, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check("resync_fall_reload_high", sclk8, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
    check("resync_fall_high_3_after", sclk8, 1'b1);
    step(1'b0, 1'b0);
    check("resync_fall_low_4_after", sclk8, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0);

    // Rising-edge resync while SCLK high at cnt=2: high phase is lengthened.
    step(1'b1, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    check("resync_rise_still_high", sclk8, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1);
      check("resync_rise_lengthened", sclk8, 1'b1);
    end
    step(1'b0, 1'b1);
    check("resync_rise_low_4_after", sclk8, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1);

    // SYNC toggling every cycle: SCLK held high, falls 4 after last edge.
    step(1'b1, 1'b1);
    cur_sync = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cur_sync = ~cur_sync;
      step(1'b0, cur_sync);
      check("toggle_hold_high", sclk8, 1'b1);
    end
    fall_dist = 0;
    for (int i = 0; i < 20 && sclk8 == 1'b1; i++) begin
      step(1'b0, cur_sync);
      fall_dist++;
    end
    check("toggle_fall_at_6", 1'b1, fall_dist == 6);
    for (int i = 0; i < 10; i++) step(1'b0, cur_sync);

    // Reset in the middle of a low phase.
    step(1'b1, cur_sync);
    for (int i = 0; i < 5; i++) step(1'b0, cur_sync);
    check("mid_reset_pre_low", sclk8, 1'b0);
    step(1'b1, cur_sync);
    check("mid_reset_high", sclk8, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, cur_sync);
    check("mid_reset_high3", sclk8, 1'b1);
    step(1'b0, cur_sync);
    check("mid_reset_low4", sclk8, 1'b0);

    // Randomized line activity with occasional resets and toggle bursts.
    for (int i = 0; i < 4000; i++) begin
      logic r;
      r = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 49) == 0) begin
        for (int j = 0; j < int'($urandom_range(1, 6)); j++) begin
          cur_sync = ~cur_sync;
          step(1'b0, cur_sync);
        end
      end else begin
        if ($urandom_range(0, 11) == 0) cur_sync = ~cur_sync;
        step(r, cur_sync);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
